// File: rtl/pipelined_pow2_shift_divider.sv
// Runtime-amount shifter / signed power-of-two divider on valid/ready streams, SW+1 register stages.
// Define POW2_SHIFT_INEXACT_EN to add down_inexact (nonzero remainder flag aligned with down_data).
module pipelined_pow2_shift_divider #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_sh,
    input  logic [1:0]    up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
`ifdef POW2_SHIFT_INEXACT_EN
    ,
    output logic          down_inexact
`endif
);

    localparam logic [N-1:0] ONES = '1;
    localparam logic [SW:0]  N_L  = (SW+1)'(N);

    logic [SW:0]   r_valid;
    logic [SW:0]   r_fill;
    logic [N-1:0]  r_data [0:SW];
    logic [SW-1:0] r_sh   [0:SW];
    logic [1:0]    r_mode [0:SW];

    logic [SW:0]   w_adv;
    logic [N-1:0]  w_shift [1:SW];
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_biased;
    logic          w_fill0;
    logic          w_sh_big;

    // Stage 0: bias negative dividends by 2^s-1 (mask saturates to all ones when s >= N).
    always_comb begin
        w_sh_big = ({1'b0, up_sh} >= N_L);
        w_mask   = ~(ONES << up_sh);
        w_biased = up_data;
        w_fill0  = 1'b0;
        case (up_mode)
            2'b01: w_fill0 = up_data[N-1];
            2'b11: begin
                if (up_data[N-1]) w_biased = up_data + w_mask;
                // A small negative operand can be biased up to a non-negative value whose
                // quotient is zero, so the fill follows the biased value; s >= N always gives 0.
                w_fill0 = w_biased[N-1] && !w_sh_big;
            end
            default: ;
        endcase
    end

    // Handshake: a stage advances when it is empty or everything downstream of it is able to
    // move; the last stage moves on down_ready. up_ready is stage 0 advancing (combinational).
    always_comb begin
        for (int k = 0; k <= SW; k++) begin
            w_adv[k] = down_ready;
            for (int j = k; j <= SW; j++) begin
                if (!r_valid[j]) w_adv[k] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 1; k <= SW; k++) begin
            w_shift[k] = r_data[k-1];
            if (r_sh[k-1][k-1]) begin
                if (r_mode[k-1] == 2'b10)
                    w_shift[k] = r_data[k-1] << (1 << (k-1));
                else if (r_fill[k-1])
                    w_shift[k] = ~(~r_data[k-1] >> (1 << (k-1)));
                else
                    w_shift[k] = r_data[k-1] >> (1 << (k-1));
            end
        end
    end

`ifdef POW2_SHIFT_INEXACT_EN
    logic [N-1:0] r_raw [0:SW];
    logic [SW:0]  r_inex;
    logic [N-1:0] w_raw [1:SW];
    logic [SW:0]  w_inex;

    // The unbiased operand rides alongside; any set bit falling off its bottom is remainder.
    always_comb begin
        w_inex[0] = 1'b0;
        for (int k = 1; k <= SW; k++) begin
            w_raw[k]  = r_raw[k-1];
            w_inex[k] = r_inex[k-1];
            if (r_sh[k-1][k-1] && r_mode[k-1] != 2'b10) begin
                w_inex[k] = r_inex[k-1] | (|(r_raw[k-1] & ~(ONES << (1 << (k-1)))));
                w_raw[k]  = r_raw[k-1] >> (1 << (k-1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inex <= '0;
            for (int k = 0; k <= SW; k++) r_raw[k] <= '0;
        end else begin
            if (w_adv[0]) begin
                r_raw[0]  <= up_data;
                r_inex[0] <= 1'b0;
            end
            for (int k = 1; k <= SW; k++) begin
                if (w_adv[k]) begin
                    r_raw[k]  <= w_raw[k];
                    r_inex[k] <= w_inex[k];
                end
            end
        end
    end

    assign down_inexact = r_inex[SW];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_fill  <= '0;
            for (int k = 0; k <= SW; k++) begin
                r_data[k] <= '0;
                r_sh[k]   <= '0;
                r_mode[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= up_valid;
                r_data[0]  <= w_biased;
                r_sh[0]    <= up_sh;
                r_mode[0]  <= up_mode;
                r_fill[0]  <= w_fill0;
            end
            for (int k = 1; k <= SW; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= w_shift[k];
                    r_sh[k]    <= r_sh[k-1];
                    r_mode[k]  <= r_mode[k-1];
                    r_fill[k]  <= r_fill[k-1];
                end
            end
        end
    end

    assign up_ready   = w_adv[0];
    assign down_valid = r_valid[SW];
    assign down_data  = r_data[SW];

endmodule
